// File: rtl/hdmi_period_decode.sv
// hdmi_period_decode
//   Three-channel HDMI TMDS/TERC4 symbol decoder with period tracking.
//   Stage 1 registers per-channel lookups (control code, TERC4 nibble, guard
//   band, TMDS byte); stage 2 runs the period FSM and registers the outputs.
//   Latency from an in_valid strobe to out_valid is two clocks.
// Ports:
//   clk, reset_n (sync, active low)
//   in_valid, in[29:0] = {ch2, ch1, ch0}
//   out_valid, mode[2:0], pixel_valid, pixel[23:0], sync[1:0] = {vsync, hsync},
//   island_valid, island_start, island_data[11:0], sym_err, err_count[ERR_W-1:0]
module hdmi_period_decode #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int ISLAND_MAX   = 576,
  parameter int ERR_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [29:0]      in,
  output logic             out_valid,
  output logic [2:0]       mode,
  output logic             pixel_valid,
  output logic [23:0]      pixel,
  output logic [1:0]       sync,
  output logic             island_valid,
  output logic             island_start,
  output logic [11:0]      island_data,
  output logic             sym_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
  localparam int GB_W  = $clog2(GUARD_LEN + 1);
  localparam int ISL_W = $clog2(ISLAND_MAX + 1);
  localparam logic [PRE_W-1:0] PRE_FULL = PRE_W'(PREAMBLE_LEN);
  localparam logic [GB_W-1:0]  GB_FULL  = GB_W'(GUARD_LEN);
  localparam logic [ISL_W-1:0] ISL_FULL = ISL_W'(ISLAND_MAX);
  localparam logic [9:0] GB_A = 10'b1011001100;
  localparam logic [9:0] GB_B = 10'b0100110011;

  typedef enum logic [2:0] {
    S_CONTROL  = 3'd0,
    S_VID_PRE  = 3'd1,
    S_VID_GB   = 3'd2,
    S_VIDEO    = 3'd3,
    S_DI_PRE   = 3'd4,
    S_DI_GB    = 3'd5,
    S_ISLAND   = 3'd6,
    S_DI_TRAIL = 3'd7
  } state_t;

  // {hit, D1, D0}
  function automatic logic [2:0] ctrl_dec(input logic [9:0] s);
    logic [2:0] r;
    r = '0;
    case (s)
      10'h354: r = 3'b100;
      10'h0AB: r = 3'b101;
      10'h154: r = 3'b110;
      10'h2AB: r = 3'b111;
      default: r = '0;
    endcase
    return r;
  endfunction

  // {hit, nibble}
  function automatic logic [4:0] terc_dec(input logic [9:0] s);
    logic [4:0] r;
    r = '0;
    case (s)
      10'b1010011100: r = 5'h10;
      10'b1001100011: r = 5'h11;
      10'b1011100100: r = 5'h12;
      10'b1011100010: r = 5'h13;
      10'b0101110001: r = 5'h14;
      10'b0100011110: r = 5'h15;
      10'b0110001110: r = 5'h16;
      10'b0100111100: r = 5'h17;
      10'b1011001100: r = 5'h18;
      10'b0100111001: r = 5'h19;
      10'b0110011100: r = 5'h1A;
      10'b1011000110: r = 5'h1B;
      10'b1010001110: r = 5'h1C;
      10'b1001110001: r = 5'h1D;
      10'b0101100011: r = 5'h1E;
      10'b1011000011: r = 5'h1F;
      default:        r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] tmds_dec(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] r;
    d    = s[9] ? ~s[7:0] : s[7:0];
    r    = '0;
    r[0] = d[0];
    for (int unsigned i = 1; i < 8; i++)
      r[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return r;
  endfunction

  // Stage 1: per-channel lookups
  logic            s1_valid;
  logic [2:0]      s1_ctrl;
  logic [2:0][1:0] s1_cd;
  logic [2:0]      s1_terc;
  logic [2:0][3:0] s1_tn;
  logic [2:0][7:0] s1_dat;
  logic            s1_gba0, s1_gba2, s1_gbb1, s1_gbb2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_cd    <= '0;
      s1_terc  <= '0;
      s1_tn    <= '0;
      s1_dat   <= '0;
      s1_gba0  <= 1'b0;
      s1_gba2  <= 1'b0;
      s1_gbb1  <= 1'b0;
      s1_gbb2  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        for (int unsigned i = 0; i < 3; i++) begin
          {s1_ctrl[i], s1_cd[i]} <= ctrl_dec(in[i*10 +: 10]);
          {s1_terc[i], s1_tn[i]} <= terc_dec(in[i*10 +: 10]);
          s1_dat[i]              <= tmds_dec(in[i*10 +: 10]);
        end
        s1_gba0 <= (in[9:0]   == GB_A);
        s1_gbb1 <= (in[19:10] == GB_B);
        s1_gba2 <= (in[29:20] == GB_A);
        s1_gbb2 <= (in[29:20] == GB_B);
      end
    end
  end

  // Stage 2: period FSM
  state_t           state, state_n, eff, mode_q, mode_n;
  logic [PRE_W-1:0] run_cnt, run_n;
  logic [GB_W-1:0]  gb_cnt, gb_n;
  logic [ISL_W-1:0] isl_cnt, isl_n;
  logic [1:0]       sync_n;
  logic             pv_n, iv_n, is_n, err_n;
  logic [23:0]      pix_n;
  logic [11:0]      id_n;
  logic             all_ctrl, vid_pat, di_pat, vid_gb, di_gb, own_pat, oth_pat, own_gb;

  always_comb begin
    all_ctrl = &s1_ctrl;
    vid_pat  = all_ctrl && (s1_cd[1] == 2'b01) && (s1_cd[2] == 2'b00);
    di_pat   = all_ctrl && (s1_cd[1] == 2'b01) && (s1_cd[2] == 2'b01);
    vid_gb   = s1_gba0 && s1_gbb1 && s1_gba2;
    di_gb    = s1_terc[0] && s1_gbb1 && s1_gbb2;

    // A completed guard band hands its symbol to the following period, and a
    // ch0 control code in video is handled exactly like a CONTROL symbol.
    eff = state;
    if (state == S_VID_GB   && gb_cnt == GB_FULL) eff = S_VIDEO;
    if (state == S_DI_GB    && gb_cnt == GB_FULL) eff = S_ISLAND;
    if (state == S_DI_TRAIL && gb_cnt == GB_FULL) eff = S_CONTROL;
    if (eff == S_VIDEO && s1_ctrl[0])             eff = S_CONTROL;

    own_pat = (eff == S_DI_PRE) ? di_pat : vid_pat;
    oth_pat = (eff == S_DI_PRE) ? vid_pat : di_pat;
    own_gb  = (eff == S_DI_PRE || eff == S_DI_GB) ? di_gb : vid_gb;

    state_n = state;
    run_n   = run_cnt;
    gb_n    = gb_cnt;
    isl_n   = isl_cnt;
    mode_n  = mode_q;
    sync_n  = sync;
    pv_n    = 1'b0;
    pix_n   = '0;
    iv_n    = 1'b0;
    is_n    = 1'b0;
    id_n    = '0;
    err_n   = 1'b0;

    if (s1_valid) begin
      case (eff)
        S_CONTROL: begin
          gb_n    = '0;
          isl_n   = '0;
          run_n   = '0;
          state_n = S_CONTROL;
          if (all_ctrl) begin
            sync_n = s1_cd[0];
            if (vid_pat) begin
              state_n = S_VID_PRE;
              run_n   = PRE_W'(1);
            end else if (di_pat) begin
              state_n = S_DI_PRE;
              run_n   = PRE_W'(1);
            end
          end else begin
            err_n = 1'b1;
          end
        end
        S_VID_PRE, S_DI_PRE: begin
          if (all_ctrl) begin
            sync_n = s1_cd[0];
            if (own_pat) begin
              if (run_cnt != PRE_FULL) run_n = run_cnt + PRE_W'(1);
            end else if (oth_pat) begin
              state_n = (eff == S_DI_PRE) ? S_VID_PRE : S_DI_PRE;
              run_n   = PRE_W'(1);
            end else begin
              state_n = S_CONTROL;
              run_n   = '0;
            end
          end else if (own_gb && run_cnt >= PRE_FULL) begin
            state_n = (eff == S_DI_PRE) ? S_DI_GB : S_VID_GB;
            run_n   = '0;
            gb_n    = GB_W'(1);
            isl_n   = '0;
            if (eff == S_DI_PRE) sync_n = s1_tn[0][1:0];
          end else begin
            err_n   = 1'b1;
            state_n = S_CONTROL;
            run_n   = '0;
          end
        end
        S_VID_GB, S_DI_GB: begin
          if (own_gb) begin
            gb_n = gb_cnt + GB_W'(1);
            if (eff == S_DI_GB) sync_n = s1_tn[0][1:0];
          end else begin
            err_n   = 1'b1;
            state_n = S_CONTROL;
            gb_n    = '0;
          end
        end
        S_VIDEO: begin
          state_n = S_VIDEO;
          gb_n    = '0;
          pv_n    = 1'b1;
          pix_n   = s1_dat;
        end
        S_ISLAND: begin
          if (s1_gbb1 && s1_gbb2) begin
            state_n = S_DI_TRAIL;
            gb_n    = GB_W'(1);
            if (s1_terc[0]) sync_n = s1_tn[0][1:0];
          end else if ((&s1_terc) && isl_cnt < ISL_FULL) begin
            state_n = S_ISLAND;
            gb_n    = '0;
            isl_n   = isl_cnt + ISL_W'(1);
            iv_n    = 1'b1;
            is_n    = (state == S_DI_GB);
            id_n    = s1_tn;
            sync_n  = s1_tn[0][1:0];
          end else begin
            err_n   = 1'b1;
            state_n = S_CONTROL;
            gb_n    = '0;
            isl_n   = '0;
          end
        end
        S_DI_TRAIL: begin
          if (s1_gbb1 && s1_gbb2) begin
            gb_n = gb_cnt + GB_W'(1);
            if (s1_terc[0]) sync_n = s1_tn[0][1:0];
          end else begin
            err_n   = 1'b1;
            state_n = S_CONTROL;
            gb_n    = '0;
            isl_n   = '0;
          end
        end
        default: begin
          state_n = S_CONTROL;
        end
      endcase
      mode_n = state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_CONTROL;
      run_cnt      <= '0;
      gb_cnt       <= '0;
      isl_cnt      <= '0;
      mode_q       <= S_CONTROL;
      out_valid    <= 1'b0;
      pixel_valid  <= 1'b0;
      pixel        <= '0;
      sync         <= '0;
      island_valid <= 1'b0;
      island_start <= 1'b0;
      island_data  <= '0;
      sym_err      <= 1'b0;
      err_count    <= '0;
    end else begin
      state        <= state_n;
      run_cnt      <= run_n;
      gb_cnt       <= gb_n;
      isl_cnt      <= isl_n;
      mode_q       <= mode_n;
      out_valid    <= s1_valid;
      pixel_valid  <= pv_n;
      pixel        <= pix_n;
      sync         <= sync_n;
      island_valid <= iv_n;
      island_start <= is_n;
      island_data  <= id_n;
      sym_err      <= err_n;
      if (err_n && err_count != '1) err_count <= err_count + ERR_W'(1);
    end
  end

  assign mode = mode_q;

endmodule

// File: doc/hdmi_period_decode.md
# hdmi_period_decode

Three-channel HDMI TMDS/TERC4 symbol decoder with period tracking. It accepts one 10-bit symbol per channel per strobe from the deserialisers and classifies each symbol time into one of these periods: control, preamble, guard band, video, or data island. It then emits decoded pixels, sync, and TERC4 island nibbles, all aligned to a common latency. It replaces the single-channel combinational-lookup decoder and sits between the channel deserialisers and the pixel and packet consumers.

## Interface
Parameters:
- PREAMBLE_LEN, 8: number of identical preamble control symbols required before a guard band is accepted.
- GUARD_LEN, 2: number of guard-band symbols in each leading or trailing guard band.
- ISLAND_MAX, 576: maximum number of island symbols (18 packets × 32) before the island is aborted.
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk, in, 1: symbol clock.
- reset_n, in, 1: synchronous, active-low reset.
- in_valid, in, 1: symbol strobe; `in` is sampled only when this is high.
- in, in, 30: {ch2, ch1, ch0}, 10 bits per channel.
- out_valid, out, 1: the output bundle is valid this cycle.
- mode, out, 3: 0 CONTROL, 1 VID_PRE, 2 VID_GB, 3 VIDEO, 4 DI_PRE, 5 DI_GB, 6 ISLAND, 7 DI_TRAIL.
- pixel_valid, out, 1: high when the symbol is in VIDEO.
- pixel, out, 24: {ch2, ch1, ch0} TMDS-decoded bytes.
- sync, out, 2: {vsync, hsync}.
- island_valid, out, 1: high when the symbol is in ISLAND.
- island_start, out, 1: one-cycle pulse on the first ISLAND symbol.
- island_data, out, 12: {ch2, ch1, ch0} TERC4 nibbles.
- sym_err, out, 1: the symbol is illegal for the current state.
- err_count, out, ERR_W: saturating count of sym_err events.

## Operation
- **Stage 1 (registered lookup per channel):**
  - Control-code match: 0x354, 0x0AB, 0x154, 0x2AB map to D1:D0 = 00, 01, 10, 11.
  - TERC4 match against the 16 HDMI 1.3 codes.
  - Guard-band match: GB_A = 10'b1011001100, GB_B = 10'b0100110011.
  - TMDS data decode: bit 9 inverts bits 7:0; bit 8 selects XOR (1) or XNOR (0) chaining.
- **Stage 2:** the finite state machine and output registers. The state only advances on strobes with in_valid high.
- **Preamble patterns:**
  - Video preamble: ch1 = CTRL01, ch2 = CTRL00.
  - Island preamble: ch1 = CTRL01, ch2 = CTRL01.
- **State transitions:**
  - CONTROL: all three channels carry control codes. sync comes from ch0 D1:D0. A preamble pattern enters VID_PRE or DI_PRE with the run counter set to 1. A control symbol on ch0 with a non-control code on ch1 or ch2 raises sym_err and stays in CONTROL.
  - VID_PRE / DI_PRE: the run counter increments while the same pattern repeats.
    - A different control pattern returns to CONTROL, or enters the other preamble state with the counter set to 1.
    - A guard band with counter ≥ PREAMBLE_LEN enters the guard-band state. Video requires ch0 = GB_A, ch1 = GB_B, ch2 = GB_A. Island requires ch1 = ch2 = GB_B and ch0 a TERC4 code.
    - A guard band with counter < PREAMBLE_LEN, or any other symbol, raises sym_err and goes to CONTROL.
  - VID_GB / DI_GB: exactly GUARD_LEN guard-band symbols, then the next symbol enters VIDEO or ISLAND. A short guard band raises sym_err and goes to CONTROL. In DI_GB, sync is taken from the ch0 TERC4 bits 1:0.
  - VIDEO: pixel is the TMDS decode of all channels and sync holds its last value. A control code on ch0 ends video; that symbol is treated as CONTROL (mode 0) and updates sync.
  - ISLAND: all channels must be TERC4. island_data carries the nibbles and sync = ch0 nibble bits 1:0.
    - ch1 = ch2 = GB_B enters DI_TRAIL.
    - A non-TERC4 symbol, or the island counter exceeding ISLAND_MAX, raises sym_err and goes to CONTROL.
  - DI_TRAIL: GUARD_LEN guard-band symbols, then CONTROL. A short trailing guard band raises sym_err and goes to CONTROL.
- **Output mode:** mode is the state assigned to that symbol. For example, the first guard-band symbol reports VID_GB.
- **Gated outputs:** pixel and island_data are zero when their valid flag is low.
- **err_count:** increments on every sym_err and saturates at all-ones.

## Timing
- Latency is 2 clocks from an in_valid strobe to out_valid. The pipeline is fully pipelined with no stalls and no back-pressure.
- When in_valid is low: no state change, and out_valid is low two cycles later.
- Reset (synchronous, while reset_n is low):
  - mode = CONTROL; all counters = 0.
  - out_valid, pixel_valid, island_valid, island_start, sym_err = 0.
  - pixel, sync, island_data, err_count = 0.
  - Both pipeline stages are flushed.
- Reset asserted mid-period discards everything in flight. No out_valid is produced for those symbols.
- Counter boundaries:
  - The preamble run counter saturates at PREAMBLE_LEN.
  - The island counter is compared before increment: symbol number ISLAND_MAX + 1 errors.

## Test plan
- **Reset:** hold reset_n low for 4 cycles with in_valid high → all outputs 0, mode 0, out_valid 0. After release, the first out_valid appears 2 cycles after the first strobe.
- **Control sync:** ch0 = 0x2AB, ch1 = ch2 = 0x354 → mode 0, sync = 2'b11, sym_err 0.
- **Video entry and pixel decode:**
  - Stimulus: 8 video-preamble symbols, then 2 video guard bands, then pixels {0x100, 0x3FF, 0x100}, then ch0 = 0x354.
  - Response: modes 1×8, 2×2, 3; pixel = 24'h000000; mode returns to 0 with sync 00.
- **Short preamble:** 7 preamble symbols then a guard band → sym_err pulses once, mode 0, err_count = 1.
- **Island:**
  - Stimulus: 8 island-preamble symbols, 2 DI guard bands (ch0 = TERC4_C), 32 TERC4 symbols (ch0 = TERC4_5, ch1 = TERC4_A, ch2 = TERC4_3), 2 trailing guard bands, then control.
  - Response: island_start on the first island symbol; island_data = 12'h3A5 ×32; sync = 2'b01; modes 7×2 then 0.
- **Overlong island and strobe gaps:** ISLAND_MAX + 1 island symbols with in_valid deasserted every other cycle → sym_err on symbol 577, mode 0, no extra outputs during the gaps.
